// File: rtl/axis_packet_truncator.sv
// AXI-Stream packet length limiter with a registered 2-entry skid buffer on the output.
// Optional macro AXIS_PACKET_TRUNCATOR_STATS_EN adds a saturating truncation counter.
module axis_packet_truncator #(
  parameter int AXIS_BYTES = 1,
  parameter int MAX_BEATS  = 1024,
  parameter int CTR_WIDTH  = $clog2(MAX_BEATS + 1)
) (
  input  logic                    clk,
  input  logic                    sreset,
`ifdef AXIS_PACKET_TRUNCATOR_STATS_EN
  input  logic                    stats_clear,
  output logic [15:0]             truncated_count,
`endif
  output logic                    axis_i_tready,
  input  logic                    axis_i_tvalid,
  input  logic                    axis_i_tlast,
  input  logic [AXIS_BYTES*8-1:0] axis_i_tdata,
  input  logic                    axis_o_tready,
  output logic                    axis_o_tvalid,
  output logic                    axis_o_tlast,
  output logic [AXIS_BYTES*8-1:0] axis_o_tdata,
  output logic                    truncated
);

  localparam int W = AXIS_BYTES * 8;
  localparam logic [CTR_WIDTH-1:0] LAST_IDX = CTR_WIDTH'(MAX_BEATS - 1);

  typedef enum logic {PASS, DISCARD} state_t;

  state_t               state, state_next;
  logic [CTR_WIDTH-1:0] beat_ctr, beat_ctr_next;
  logic                 trunc_event;

  logic [1:0]           fill;
  logic [W-1:0]         head_data, tail_data;
  logic                 head_last, tail_last;

  logic                 accept, push, pop, at_limit, tlast_in;

  // Ready depends only on registered state, so no path from axis_o_tready.
  assign axis_i_tready = !sreset && ((state == DISCARD) || (fill != 2'd2));
  assign accept        = axis_i_tvalid && axis_i_tready;
  assign push          = accept && (state == PASS);
  assign pop           = axis_o_tvalid && axis_o_tready;
  assign at_limit      = (beat_ctr == LAST_IDX);
  assign tlast_in      = axis_i_tlast || at_limit;

  assign axis_o_tvalid = (fill != 2'd0);
  assign axis_o_tdata  = head_data;
  assign axis_o_tlast  = head_last;

  always_comb begin
    state_next    = state;
    beat_ctr_next = beat_ctr;
    trunc_event   = 1'b0;
    case (state)
      PASS: begin
        if (accept) begin
          if (axis_i_tlast) begin
            beat_ctr_next = '0;
          end else if (at_limit) begin
            beat_ctr_next = '0;
            state_next    = DISCARD;
            trunc_event   = 1'b1;
          end else begin
            beat_ctr_next = beat_ctr + 1'b1;
          end
        end
      end
      DISCARD: begin
        if (accept && axis_i_tlast) state_next = PASS;
      end
      default: state_next = PASS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sreset) begin
      state     <= PASS;
      beat_ctr  <= '0;
      truncated <= 1'b0;
    end else begin
      state     <= state_next;
      beat_ctr  <= beat_ctr_next;
      truncated <= trunc_event;
    end
  end

  // Head always feeds the output; tail only fills when the head is stalled.
  always_ff @(posedge clk) begin
    if (sreset) begin
      fill      <= 2'd0;
      head_data <= '0;
      head_last <= 1'b0;
      tail_data <= '0;
      tail_last <= 1'b0;
    end else begin
      case (fill)
        2'd0: begin
          if (push) begin
            head_data <= axis_i_tdata;
            head_last <= tlast_in;
            fill      <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_data <= axis_i_tdata;
            head_last <= tlast_in;
          end else if (pop) begin
            fill <= 2'd0;
          end else if (push) begin
            tail_data <= axis_i_tdata;
            tail_last <= tlast_in;
            fill      <= 2'd2;
          end
        end
        2'd2: begin
          if (pop) begin
            head_data <= tail_data;
            head_last <= tail_last;
            fill      <= 2'd1;
          end
        end
        default: fill <= 2'd0;
      endcase
    end
  end

`ifdef AXIS_PACKET_TRUNCATOR_STATS_EN
  logic [15:0] count_q;

  // A clear that coincides with a truncation keeps that truncation.
  always_ff @(posedge clk) begin
    if (sreset) begin
      count_q <= 16'd0;
    end else if (stats_clear) begin
      count_q <= trunc_event ? 16'd1 : 16'd0;
    end else if (trunc_event && (count_q != 16'hFFFF)) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign truncated_count = count_q;
`endif

endmodule

// File: tb/tb_axis_packet_truncator.sv
// Randomized self-checking bench for axis_packet_truncator (MAX_BEATS=4) against a packet-level model.
module tb_axis_packet_truncator;

  localparam int MAX_BEATS = 4;

  logic       clk = 1'b0;
  logic       sreset;
  logic       axis_i_tready;
  logic       axis_i_tvalid;
  logic       axis_i_tlast;
  logic [7:0] axis_i_tdata;
  logic       axis_o_tready;
  logic       axis_o_tvalid;
  logic       axis_o_tlast;
  logic [7:0] axis_o_tdata;
  logic       truncated;
`ifdef AXIS_PACKET_TRUNCATOR_STATS_EN
  logic       stats_clear;
  logic [15:0] truncated_count;
`endif

  axis_packet_truncator #(
    .AXIS_BYTES(1),
    .MAX_BEATS (MAX_BEATS)
  ) dut (
    .clk            (clk),
    .sreset         (sreset),
`ifdef AXIS_PACKET_TRUNCATOR_STATS_EN
    .stats_clear    (stats_clear),
    .truncated_count(truncated_count),
`endif
    .axis_i_tready  (axis_i_tready),
    .axis_i_tvalid  (axis_i_tvalid),
    .axis_i_tlast   (axis_i_tlast),
    .axis_i_tdata   (axis_i_tdata),
    .axis_o_tready  (axis_o_tready),
    .axis_o_tvalid  (axis_o_tvalid),
    .axis_o_tlast   (axis_o_tlast),
    .axis_o_tdata   (axis_o_tdata),
    .truncated      (truncated)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t      exp_q[$];
  beat_t      got;
  logic [7:0] pkt[16];
  int compared = 0;
  int mismatched = 0;
  int cycle = 0;
  int exp_trunc = 0;
  int seen_trunc = 0;
  int last_trunc_cycle = -1;
  int trunc_accept_cycle = -2;
  int last_accept_cycle = -1;
  int last_out_cycle = -1;
  int stall_count = 0;
  bit random_ready = 0;
  bit random_gaps = 0;
  bit prev_stall = 0;
  bit prev_trunc = 0;
  logic [7:0] prev_data;
  logic       prev_last;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cycle);
    end
  endtask

  // Output monitor: scoreboard pop on handshake, hold-stability and pulse-width checks.
  always @(negedge clk) begin
    if (prev_stall) begin
      checkOutput("hold_valid", axis_o_tvalid, 1);
      checkOutput("hold_data", axis_o_tdata, prev_data);
      checkOutput("hold_last", axis_o_tlast, prev_last);
    end
    if (axis_o_tvalid === 1'b1 && axis_o_tready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_beat", exp_q.size(), 1);
      end else begin
        got = exp_q.pop_front();
        checkOutput("out_data", axis_o_tdata, got.data);
        checkOutput("out_last", axis_o_tlast, got.last);
      end
      last_out_cycle = cycle;
    end
    if (prev_trunc) checkOutput("trunc_pulse", truncated, 0);
    if (truncated === 1'b1) begin
      seen_trunc++;
      last_trunc_cycle = cycle;
    end
    prev_trunc = (truncated === 1'b1);
    prev_stall = (axis_o_tvalid === 1'b1) && (axis_o_tready === 1'b0) && !sreset;
    prev_data  = axis_o_tdata;
    prev_last  = axis_o_tlast;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (random_ready) axis_o_tready = 1'($urandom_range(0, 1));
    end
  end

  // Drives one beat starting just after a rising edge and returns just after its accepting edge.
  task automatic applyStimulus(input logic [7:0] data, input logic last);
    int waited;
    bit acc;
    waited = 0;
    acc = 0;
    axis_i_tvalid = 1'b1;
    axis_i_tdata  = data;
    axis_i_tlast  = last;
    while (!acc && waited < 1000) begin
      @(negedge clk);
      acc = axis_i_tready;
      @(posedge clk);
      if (!acc) begin
        waited++;
        stall_count++;
      end
    end
    #1;
    axis_i_tvalid = 1'b0;
    last_accept_cycle = cycle;
    checkOutput("in_accept", acc, 1);
  endtask

  // Model: keep the first MAX_BEATS beats, tlast on the packet's real or forced end.
  task automatic sendPacket(input int len);
    int kept;
    kept = (len < MAX_BEATS) ? len : MAX_BEATS;
    for (int i = 0; i < kept; i++)
      exp_q.push_back('{data: pkt[i], last: (i == kept - 1)});
    if (len > MAX_BEATS) exp_trunc++;
    for (int i = 0; i < len; i++) begin
      if (random_gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      applyStimulus(pkt[i], (i == len - 1));
      if (i == MAX_BEATS - 1 && len > MAX_BEATS) trunc_accept_cycle = last_accept_cycle;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int stall0;
    int waited;
    sreset        = 1'b1;
    axis_i_tvalid = 1'b0;
    axis_i_tlast  = 1'b0;
    axis_i_tdata  = 8'h00;
    axis_o_tready = 1'b1;
`ifdef AXIS_PACKET_TRUNCATOR_STATS_EN
    stats_clear   = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_tready", axis_i_tready, 0);
    checkOutput("reset_tvalid", axis_o_tvalid, 0);
    checkOutput("reset_tlast", axis_o_tlast, 0);
    checkOutput("reset_tdata", axis_o_tdata, 0);
    checkOutput("reset_truncated", truncated, 0);
    @(posedge clk);
    #1;
    sreset = 1'b0;

    // Short packet: back-to-back, latency 1, no truncation.
    stall0 = stall_count;
    pkt[0] = 8'h11; pkt[1] = 8'h22; pkt[2] = 8'h33;
    sendPacket(3);
    @(negedge clk);
    #1;
    checkOutput("latency", last_out_cycle, last_accept_cycle);
    checkOutput("short_stalls", stall_count - stall0, 0);
    idle(2);
    checkOutput("short_trunc", seen_trunc, 0);

    // Exactly MAX_BEATS beats, then a long packet that must count from zero.
    for (int i = 0; i < 4; i++) pkt[i] = 8'h41 + 8'(i);
    sendPacket(4);
    idle(2);
    checkOutput("exact_trunc", seen_trunc, 0);
    stall0 = stall_count;
    for (int i = 0; i < 7; i++) pkt[i] = 8'h01 + 8'(i);
    sendPacket(7);
    pkt[0] = 8'hA0; pkt[1] = 8'hA1;
    sendPacket(2);
    idle(3);
    checkOutput("discard_stalls", stall_count - stall0, 0);
    checkOutput("long_trunc", seen_trunc, 1);
    checkOutput("trunc_timing", last_trunc_cycle, trunc_accept_cycle);

    // Reset after beat 2 of a 6-beat packet.
    exp_q.push_back('{data: 8'h61, last: 1'b0});
    exp_q.push_back('{data: 8'h62, last: 1'b0});
    applyStimulus(8'h61, 1'b0);
    applyStimulus(8'h62, 1'b0);
    sreset = 1'b1;
    @(negedge clk);
    checkOutput("mid_reset_tready", axis_i_tready, 0);
    @(posedge clk);
    #1;
    sreset = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_tvalid", axis_o_tvalid, 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) pkt[i] = 8'h63 + 8'(i);
    sendPacket(4);
    idle(3);
    checkOutput("reset_trunc", seen_trunc, exp_trunc);
    checkOutput("reset_drain", exp_q.size(), 0);

    // Random lengths, random data, random gaps and 50% output backpressure.
    random_ready = 1;
    random_gaps  = 1;
    for (int p = 0; p < 100; p++) begin
      int len;
      len = int'($urandom_range(1, 10));
      for (int i = 0; i < len; i++) pkt[i] = 8'($urandom);
      sendPacket(len);
    end
    random_ready = 0;
    random_gaps  = 0;
    @(posedge clk);
    #2;
    axis_o_tready = 1'b1;
    waited = 0;
    while (exp_q.size() != 0 && waited < 200) begin
      @(posedge clk);
      waited++;
    end
    idle(2);
    checkOutput("random_drain", exp_q.size(), 0);
    checkOutput("random_trunc", seen_trunc, exp_trunc);

`ifdef AXIS_PACKET_TRUNCATOR_STATS_EN
    checkOutput("stat_count", truncated_count, exp_trunc);
    stats_clear = 1'b1;
    @(posedge clk);
    #1;
    stats_clear = 1'b0;
    checkOutput("stat_clear", truncated_count, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed cycle %0d", cycle);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
